// File: rtl/obi_demux_pkg.sv
// obi_demux_pkg
// Address-map types and defaults for the 1-to-N OBI demultiplexer.
//   addr_rule_t       : {start_addr, end_addr}, start inclusive, end exclusive
//   DEFAULT_ADDR_MAP  : rule 0 = [0x0000,0x1000), rule 1 = [0x1000,0x2000)
//   OBI_ERR_RDATA     : read data returned for unmapped reads
package obi_demux_pkg;

  typedef struct packed {
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } addr_rule_t;

  // Packed array: rule 1 occupies the upper 64 bits, rule 0 the lower 64.
  localparam addr_rule_t [1:0] DEFAULT_ADDR_MAP = {
    32'h0000_1000, 32'h0000_2000,
    32'h0000_0000, 32'h0000_1000
  };

  localparam logic [31:0] OBI_ERR_RDATA = 32'hBADA_CCE5;

  // True when addr lies in [rule.start_addr, rule.end_addr).
  function automatic logic addr_in_rule(input logic [31:0] addr, input addr_rule_t rule);
    return (addr >= rule.start_addr) && (addr < rule.end_addr);
  endfunction

endpackage

// File: rtl/obi_pkg.sv
// obi_pkg
// Shared OBI request/response bundles used by initiators, targets and
// interconnect blocks.
//   obi_req_t  : req, we, be, addr, wdata  (initiator -> target)
//   obi_resp_t : gnt, rvalid, rdata        (target -> initiator)
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/obi_err_responder.sv
// obi_err_responder
// Terminates OBI accesses that hit no address rule. Grants combinationally
// and returns one rvalid exactly one cycle after every grant.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   req_i, we_i  : gated request from the demux (already qualified)
//   gnt_o        : combinational grant
//   rvalid_o     : response valid, one cycle after each grant
//   rdata_o      : ERR_RDATA for reads, 0 for writes, 0 when idle
module obi_err_responder
  import obi_demux_pkg::*;
#(
  parameter int unsigned CNT_W     = 3,
  parameter logic [31:0] ERR_RDATA = OBI_ERR_RDATA
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o
);

  logic [CNT_W-1:0] pending_q;
  logic [CNT_W-1:0] pending_d;
  logic             we_q;
  logic             we_d;

  assign gnt_o    = req_i;
  assign rvalid_o = (pending_q != {CNT_W{1'b0}});

  // Pending count and the write flag of the access being answered next.
  always_comb begin
    pending_d = pending_q + CNT_W'(gnt_o) - CNT_W'(rvalid_o);
    if (gnt_o) begin
      we_d = we_i;
    end else begin
      we_d = we_q;
    end
  end

  // Response data: writes complete with zero data.
  always_comb begin
    if (rvalid_o && !we_q) begin
      rdata_o = ERR_RDATA;
    end else begin
      rdata_o = 32'h0000_0000;
    end
  end

  // Pending counter and captured write flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q <= {CNT_W{1'b0}};
      we_q      <= 1'b0;
    end else begin
      pending_q <= pending_d;
      we_q      <= we_d;
    end
  end

endmodule

// File: rtl/obi_varlat_one_to_n_demux.sv
// obi_varlat_one_to_n_demux
// One OBI initiator fanned out to NSLAVE variable-latency targets. Requests
// are decoded and forwarded combinationally; responses are returned in order
// by only allowing a new target once every response of the previous target
// has come back. Unmapped addresses go to an internal error responder.
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   master_req_i     : request from the initiator
//   master_resp_o    : gnt/rvalid/rdata to the initiator
//   slave_req_o[]    : per-target requests (only the selected one has req)
//   slave_resp_i[]   : per-target responses
//   decode_err_o     : pulse in the cycle an unmapped request is granted
//   protocol_err_o   : sticky, rvalid seen from a target with nothing pending
module obi_varlat_one_to_n_demux
  import obi_pkg::*;
  import obi_demux_pkg::*;
#(
  parameter int unsigned          NSLAVE          = 2,
  parameter int unsigned          MAX_OUTSTANDING = 4,
  parameter addr_rule_t [NSLAVE-1:0] ADDR_MAP     = DEFAULT_ADDR_MAP,
  parameter logic [31:0]          ERR_RDATA       = OBI_ERR_RDATA
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  obi_req_t  master_req_i,
  output obi_resp_t master_resp_o,
  output obi_req_t  slave_req_o [NSLAVE],
  input  obi_resp_t slave_resp_i [NSLAVE],
  output logic      decode_err_o,
  output logic      protocol_err_o
);

  localparam int unsigned TGT_W = $clog2(NSLAVE + 1);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [TGT_W-1:0] ERR_TGT = TGT_W'(NSLAVE);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [TGT_W-1:0] cur_tgt_q;
  logic [TGT_W-1:0] cur_tgt_d;
  logic             protocol_err_q;

  logic [TGT_W-1:0] sel_s;
  logic             rsp_raw_valid_s;
  logic [31:0]      rsp_raw_data_s;
  logic             rsp_valid_s;
  logic [CNT_W-1:0] cnt_eff_s;
  logic             allowed_s;
  logic             fwd_s;
  logic             tgt_gnt_s;
  logic             err_req_s;
  logic             err_gnt_s;
  logic             err_rvalid_s;
  logic [31:0]      err_rdata_s;
  logic             accept_s;
  logic             stray_s;

  // Address decode: lowest matching rule wins, no match selects the error responder.
  always_comb begin
    sel_s = ERR_TGT;
    for (int i = NSLAVE - 1; i >= 0; i--) begin
      if (addr_in_rule(master_req_i.addr, ADDR_MAP[i])) begin
        sel_s = TGT_W'(i);
      end else begin
        sel_s = sel_s;
      end
    end
  end

  // Response source is always the target of the outstanding transactions.
  always_comb begin
    rsp_raw_valid_s = 1'b0;
    rsp_raw_data_s  = 32'h0000_0000;
    if (cur_tgt_q == ERR_TGT) begin
      rsp_raw_valid_s = err_rvalid_s;
      rsp_raw_data_s  = err_rdata_s;
    end else begin
      for (int i = 0; i < NSLAVE; i++) begin
        if (cur_tgt_q == TGT_W'(i)) begin
          rsp_raw_valid_s = slave_resp_i[i].rvalid;
          rsp_raw_data_s  = slave_resp_i[i].rdata;
        end else begin
          rsp_raw_valid_s = rsp_raw_valid_s;
          rsp_raw_data_s  = rsp_raw_data_s;
        end
      end
    end
  end

  // A response frees its slot in the same cycle, so a full or switching
  // initiator can be granted on the cycle the freeing rvalid arrives.
  assign rsp_valid_s = rsp_raw_valid_s & (cnt_q != {CNT_W{1'b0}}) & ~rst_i;
  assign cnt_eff_s   = cnt_q - CNT_W'(rsp_valid_s);
  assign allowed_s   = ~rst_i & ((cnt_eff_s == {CNT_W{1'b0}}) |
                                 ((sel_s == cur_tgt_q) & (cnt_eff_s < CNT_MAX)));
  assign fwd_s       = master_req_i.req & allowed_s;

  // Request fan-out and grant selection; non-selected targets see req = 0.
  always_comb begin
    tgt_gnt_s = 1'b0;
    for (int i = 0; i < NSLAVE; i++) begin
      slave_req_o[i]     = master_req_i;
      slave_req_o[i].req = fwd_s & (sel_s == TGT_W'(i));
      tgt_gnt_s          = tgt_gnt_s | (slave_resp_i[i].gnt & (sel_s == TGT_W'(i)));
    end
    err_req_s = fwd_s & (sel_s == ERR_TGT);
  end

  assign accept_s = (fwd_s & tgt_gnt_s) | err_gnt_s;

  // Responses from a target other than the current one, or with nothing
  // outstanding, are dropped and flagged.
  always_comb begin
    stray_s = 1'b0;
    for (int i = 0; i < NSLAVE; i++) begin
      stray_s = stray_s | (slave_resp_i[i].rvalid &
                           ((cnt_q == {CNT_W{1'b0}}) | (cur_tgt_q != TGT_W'(i))));
    end
  end

  // Next-state for the outstanding counter and current target.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(accept_s) - CNT_W'(rsp_valid_s);
    if (accept_s) begin
      cur_tgt_d = sel_s;
    end else begin
      cur_tgt_d = cur_tgt_q;
    end
  end

  // Transaction-tracking state and sticky protocol error.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q          <= {CNT_W{1'b0}};
      cur_tgt_q      <= {TGT_W{1'b0}};
      protocol_err_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      cur_tgt_q      <= cur_tgt_d;
      protocol_err_q <= protocol_err_q | stray_s;
    end
  end

  obi_err_responder #(
    .CNT_W     (CNT_W),
    .ERR_RDATA (ERR_RDATA)
  ) u_err_responder (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (err_req_s),
    .we_i     (master_req_i.we),
    .gnt_o    (err_gnt_s),
    .rvalid_o (err_rvalid_s),
    .rdata_o  (err_rdata_s)
  );

  // Initiator-facing response; data is zeroed when no response is valid.
  always_comb begin
    master_resp_o.gnt    = accept_s;
    master_resp_o.rvalid = rsp_valid_s;
    if (rsp_valid_s) begin
      master_resp_o.rdata = rsp_raw_data_s;
    end else begin
      master_resp_o.rdata = 32'h0000_0000;
    end
  end

  assign decode_err_o   = err_gnt_s;
  assign protocol_err_o = protocol_err_q;

endmodule

// File: tb/tb_obi_varlat_one_to_n_demux.sv
module tb_obi_varlat_one_to_n_demux;
  import obi_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  obi_req_t  m_req;
  obi_resp_t m_resp;
  obi_req_t  s_req [2];
  obi_resp_t s_resp [2];
  logic      dec_err;
  logic      prot_err;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  obi_varlat_one_to_n_demux #(
    .NSLAVE          (2),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .master_req_i   (m_req),
    .master_resp_o  (m_resp),
    .slave_req_o    (s_req),
    .slave_resp_i   (s_resp),
    .decode_err_o   (dec_err),
    .protocol_err_o (prot_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    m_req     = '0;
    s_resp[0] = '0;
    s_resp[1] = '0;
  endtask

  task automatic drive_req(input logic [31:0] addr, input logic we);
    m_req.req   = 1'b1;
    m_req.we    = we;
    m_req.be    = 4'hF;
    m_req.addr  = addr;
    m_req.wdata = addr ^ 32'h5A5A_0000;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    drive_req(32'h0000_0004, 1'b0);
    s_resp[0].gnt = 1'b1;
    tick();
    #3;
    n_cmp++; if (s_req[0].req !== 1'b0) begin n_mis++; $display("FAIL reset_s0_req: got %b want 0", s_req[0].req); end
    n_cmp++; if (m_resp !== '0) begin n_mis++; $display("FAIL reset_master_resp: got %h want 0", m_resp); end
    n_cmp++; if (dec_err !== 1'b0 || prot_err !== 1'b0) begin n_mis++; $display("FAIL reset_errs: got %b%b want 00", dec_err, prot_err); end
    n_cmp++; if (dut.cnt_q !== 3'd0) begin n_mis++; $display("FAIL reset_cnt: got %0d want 0", dut.cnt_q); end
    tick();
    drive_idle();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_decode();
    logic [31:0] addrs [3];
    logic [1:0]  want  [3];
    addrs[0] = 32'h0000_0FFC; want[0] = 2'b01;
    addrs[1] = 32'h0000_1000; want[1] = 2'b10;
    addrs[2] = 32'h0000_1FFC; want[2] = 2'b10;
    for (int k = 0; k < 3; k++) begin
      drive_idle();
      drive_req(addrs[k], 1'b0);
      #3;
      n_cmp++; if ({s_req[1].req, s_req[0].req} !== want[k]) begin n_mis++; $display("FAIL decode_%0d: got %b want %b", k, {s_req[1].req, s_req[0].req}, want[k]); end
      n_cmp++; if (m_resp.gnt !== 1'b0) begin n_mis++; $display("FAIL decode_nognt_%0d: got %b want 0", k, m_resp.gnt); end
      tick();
    end
    n_cmp++; if (s_req[0].addr !== 32'h0000_1FFC) begin n_mis++; $display("FAIL decode_mirror: got %h want 00001ffc", s_req[0].addr); end
    drive_idle();
    tick();
  endtask

  task automatic test_single_read();
    drive_idle();
    drive_req(32'h0000_0004, 1'b0);
    s_resp[0].gnt = 1'b1;
    #3;
    n_cmp++; if (s_req[0].req !== 1'b1 || s_req[1].req !== 1'b0) begin n_mis++; $display("FAIL single_fwd: got %b%b want 01", s_req[1].req, s_req[0].req); end
    n_cmp++; if (m_resp.gnt !== 1'b1) begin n_mis++; $display("FAIL single_gnt: got %b want 1", m_resp.gnt); end
    tick();
    drive_idle();
    for (int c = 1; c < 3; c++) begin
      #3;
      n_cmp++; if (m_resp.rvalid !== 1'b0 || dut.cnt_q !== 3'd1) begin n_mis++; $display("FAIL single_wait_%0d: got rvalid %b cnt %0d want 0/1", c, m_resp.rvalid, dut.cnt_q); end
      tick();
    end
    s_resp[0].rvalid = 1'b1;
    s_resp[0].rdata  = 32'h0000_1234;
    #3;
    n_cmp++; if (m_resp.rvalid !== 1'b1 || m_resp.rdata !== 32'h0000_1234) begin n_mis++; $display("FAIL single_rsp: got %b/%h want 1/00001234", m_resp.rvalid, m_resp.rdata); end
    tick();
    drive_idle();
    #3;
    n_cmp++; if (dut.cnt_q !== 3'd0) begin n_mis++; $display("FAIL single_cnt: got %0d want 0", dut.cnt_q); end
    tick();
  endtask

  task automatic test_full();
    drive_idle();
    s_resp[1].gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive_req(32'h0000_1000 + 32'(k * 4), 1'b0);
      #3;
      n_cmp++; if (m_resp.gnt !== 1'b1) begin n_mis++; $display("FAIL full_gnt_%0d: got %b want 1", k, m_resp.gnt); end
      tick();
    end
    drive_req(32'h0000_1010, 1'b0);
    for (int c = 0; c < 2; c++) begin
      #3;
      n_cmp++; if (m_resp.gnt !== 1'b0 || s_req[1].req !== 1'b0) begin n_mis++; $display("FAIL full_stall_%0d: got gnt %b req %b want 0/0", c, m_resp.gnt, s_req[1].req); end
      tick();
    end
    s_resp[1].rvalid = 1'b1;
    s_resp[1].rdata  = 32'h0000_00A0;
    #3;
    n_cmp++; if (m_resp.gnt !== 1'b1 || m_resp.rvalid !== 1'b1) begin n_mis++; $display("FAIL full_free: got gnt %b rvalid %b want 1/1", m_resp.gnt, m_resp.rvalid); end
    tick();
    m_req.req = 1'b0;
    #3;
    n_cmp++; if (dut.cnt_q !== 3'd4) begin n_mis++; $display("FAIL full_cnt: got %0d want 4", dut.cnt_q); end
    for (int c = 0; c < 4; c++) begin
      tick();
    end
    drive_idle();
    #3;
    n_cmp++; if (dut.cnt_q !== 3'd0) begin n_mis++; $display("FAIL full_drain: got %0d want 0", dut.cnt_q); end
    tick();
  endtask

  task automatic test_switch();
    drive_idle();
    drive_req(32'h0000_0010, 1'b0);
    s_resp[0].gnt = 1'b1;
    #3;
    n_cmp++; if (m_resp.gnt !== 1'b1) begin n_mis++; $display("FAIL switch_gnt0: got %b want 1", m_resp.gnt); end
    tick();
    s_resp[0].gnt = 1'b0;
    s_resp[1].gnt = 1'b1;
    drive_req(32'h0000_1020, 1'b0);
    for (int c = 0; c < 5; c++) begin
      #3;
      n_cmp++; if (m_resp.gnt !== 1'b0 || s_req[1].req !== 1'b0 || m_resp.rvalid !== 1'b0) begin n_mis++; $display("FAIL switch_hold_%0d: got gnt %b req %b rvalid %b want 000", c, m_resp.gnt, s_req[1].req, m_resp.rvalid); end
      tick();
    end
    s_resp[0].rvalid = 1'b1;
    s_resp[0].rdata  = 32'h0000_5555;
    #3;
    n_cmp++; if (m_resp.gnt !== 1'b1 || s_req[1].req !== 1'b1) begin n_mis++; $display("FAIL switch_grant: got gnt %b req %b want 1/1", m_resp.gnt, s_req[1].req); end
    n_cmp++; if (m_resp.rvalid !== 1'b1 || m_resp.rdata !== 32'h0000_5555) begin n_mis++; $display("FAIL switch_rsp0: got %b/%h want 1/00005555", m_resp.rvalid, m_resp.rdata); end
    tick();
    drive_idle();
    s_resp[1].rvalid = 1'b1;
    s_resp[1].rdata  = 32'h0000_6666;
    #3;
    n_cmp++; if (m_resp.rvalid !== 1'b1 || m_resp.rdata !== 32'h0000_6666) begin n_mis++; $display("FAIL switch_rsp1: got %b/%h want 1/00006666", m_resp.rvalid, m_resp.rdata); end
    tick();
    drive_idle();
    #3;
    n_cmp++; if (dut.cnt_q !== 3'd0 || prot_err !== 1'b0) begin n_mis++; $display("FAIL switch_end: got cnt %0d perr %b want 0/0", dut.cnt_q, prot_err); end
    tick();
  endtask

  task automatic test_unmapped();
    drive_idle();
    s_resp[0].gnt = 1'b1;
    s_resp[1].gnt = 1'b1;
    drive_req(32'h0000_8000, 1'b0);
    #3;
    n_cmp++; if (m_resp.gnt !== 1'b1 || dec_err !== 1'b1) begin n_mis++; $display("FAIL unmap_gnt: got gnt %b derr %b want 1/1", m_resp.gnt, dec_err); end
    n_cmp++; if (s_req[0].req !== 1'b0 || s_req[1].req !== 1'b0) begin n_mis++; $display("FAIL unmap_nofwd: got %b%b want 00", s_req[1].req, s_req[0].req); end
    n_cmp++; if (m_resp.rvalid !== 1'b0) begin n_mis++; $display("FAIL unmap_early: got %b want 0", m_resp.rvalid); end
    tick();
    drive_req(32'h0000_2000, 1'b1);
    #3;
    n_cmp++; if (m_resp.gnt !== 1'b1 || dec_err !== 1'b1 || s_req[1].req !== 1'b0) begin n_mis++; $display("FAIL unmap_b2b_gnt: got gnt %b derr %b req1 %b want 1/1/0", m_resp.gnt, dec_err, s_req[1].req); end
    n_cmp++; if (m_resp.rvalid !== 1'b1 || m_resp.rdata !== 32'hBADA_CCE5) begin n_mis++; $display("FAIL unmap_rsp_rd: got %b/%h want 1/badacce5", m_resp.rvalid, m_resp.rdata); end
    tick();
    drive_req(32'hFFFF_FFF0, 1'b0);
    #3;
    n_cmp++; if (m_resp.rvalid !== 1'b1 || m_resp.rdata !== 32'h0000_0000) begin n_mis++; $display("FAIL unmap_rsp_wr: got %b/%h want 1/00000000", m_resp.rvalid, m_resp.rdata); end
    tick();
    drive_idle();
    #3;
    n_cmp++; if (m_resp.rvalid !== 1'b1 || m_resp.rdata !== 32'hBADA_CCE5 || dec_err !== 1'b0) begin n_mis++; $display("FAIL unmap_rsp_last: got %b/%h derr %b want 1/badacce5/0", m_resp.rvalid, m_resp.rdata, dec_err); end
    tick();
    #3;
    n_cmp++; if (m_resp.rvalid !== 1'b0 || dut.cnt_q !== 3'd0) begin n_mis++; $display("FAIL unmap_end: got rvalid %b cnt %0d want 0/0", m_resp.rvalid, dut.cnt_q); end
    tick();
  endtask

  task automatic test_protocol();
    drive_idle();
    s_resp[1].rvalid = 1'b1;
    s_resp[1].rdata  = 32'hDEAD_0001;
    #3;
    n_cmp++; if (m_resp.rvalid !== 1'b0) begin n_mis++; $display("FAIL prot_drop: got %b want 0", m_resp.rvalid); end
    tick();
    drive_idle();
    for (int c = 0; c < 3; c++) begin
      #3;
      n_cmp++; if (prot_err !== 1'b1) begin n_mis++; $display("FAIL prot_sticky_%0d: got %b want 1", c, prot_err); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    drive_idle();
    s_resp[0].gnt = 1'b1;
    drive_req(32'h0000_0020, 1'b0);
    tick();
    drive_req(32'h0000_0024, 1'b0);
    tick();
    drive_idle();
    #3;
    n_cmp++; if (dut.cnt_q !== 3'd2) begin n_mis++; $display("FAIL rstmid_pre: got %0d want 2", dut.cnt_q); end
    tick();
    rst = 1'b1;
    drive_req(32'h0000_1000, 1'b0);
    s_resp[1].gnt    = 1'b1;
    s_resp[0].rvalid = 1'b1;
    s_resp[0].rdata  = 32'h0000_0099;
    #3;
    n_cmp++; if (dut.cnt_q !== 3'd0 || prot_err !== 1'b0 || dec_err !== 1'b0) begin n_mis++; $display("FAIL rstmid_state: got cnt %0d perr %b derr %b want 0/0/0", dut.cnt_q, prot_err, dec_err); end
    n_cmp++; if (m_resp !== '0 || s_req[0].req !== 1'b0 || s_req[1].req !== 1'b0) begin n_mis++; $display("FAIL rstmid_out: got resp %h req %b%b want 0/00", m_resp, s_req[1].req, s_req[0].req); end
    tick();
    rst = 1'b0;
    #3;
    n_cmp++; if (m_resp.gnt !== 1'b1 || s_req[1].req !== 1'b1 || m_resp.rvalid !== 1'b0) begin n_mis++; $display("FAIL rstmid_new: got gnt %b req %b rvalid %b want 1/1/0", m_resp.gnt, s_req[1].req, m_resp.rvalid); end
    tick();
    drive_idle();
    s_resp[1].rvalid = 1'b1;
    s_resp[1].rdata  = 32'h0000_0077;
    #3;
    n_cmp++; if (prot_err !== 1'b1) begin n_mis++; $display("FAIL rstmid_perr: got %b want 1", prot_err); end
    n_cmp++; if (m_resp.rvalid !== 1'b1 || m_resp.rdata !== 32'h0000_0077) begin n_mis++; $display("FAIL rstmid_rsp: got %b/%h want 1/00000077", m_resp.rvalid, m_resp.rdata); end
    tick();
    drive_idle();
    #3;
    n_cmp++; if (dut.cnt_q !== 3'd0) begin n_mis++; $display("FAIL rstmid_end: got %0d want 0", dut.cnt_q); end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_decode();
    test_single_read();
    test_full();
    test_switch();
    test_unmapped();
    test_protocol();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
